tdm_demux1_4: RTL and testbench

// - Sequential 1:4 demultiplexer, the receive-side counterpart of mux4_1.
// - One word stream enters; words are routed to four registered channel outputs Y0..Y3.
// - Routing uses one of two sources:
//   - an internal TDM slot counter, aligned by frame_sync; or
//   - the external select S (direct mode).
// - Sits after a 4-channel time-multiplexed link and rebuilds the per-channel values.

---
 rtl/tdm_pkg.sv | 11 +
 rtl/tdm_demux1_4_if.sv | 30 +++
 rtl/tdm_slot_ctr.sv | 31 +++
 rtl/tdm_demux1_4.sv | 110 +++++++++++
 tb/tb_tdm_demux1_4.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM receive path: channel count, slot counter
// width and the two-state framing FSM encoding.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/tdm_demux1_4_if.sv
// Bus bundle between a TDM link source and the 1:4 demultiplexer.
// The master drives the word stream and routing controls; the slave
// returns the four registered channels and the status strobes.
interface tdm_demux1_4_if #(parameter int WIDTH = 1);
  import tdm_pkg::*;

  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              frame_sync;
  logic              ext_sel;
  logic [SLOT_W-1:0] S;
  logic [WIDTH-1:0]  Y0;
  logic [WIDTH-1:0]  Y1;
  logic [WIDTH-1:0]  Y2;
  logic [WIDTH-1:0]  Y3;
  logic [NUM_CH-1:0] y_valid;
  logic              frame_valid;
  logic              frame_err;

  modport master (
    output din, din_valid, frame_sync, ext_sel, S,
    input  Y0, Y1, Y2, Y3, y_valid, frame_valid, frame_err
  );

  modport slave (
    input  din, din_valid, frame_sync, ext_sel, S,
    output Y0, Y1, Y2, Y3, y_valid, frame_valid, frame_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Two-bit TDM slot counter. Clear forces slot 0, load jumps to slot 1
// (the word that carried frame_sync has already taken slot 0), advance
// wraps modulo NUM_CH. last_slot flags the final slot of a frame.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_one,
  input  logic              advance,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  // Slot register; clear wins over load, load wins over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= SLOT_W'(1);
    end else if (advance) begin
      slot <= slot + SLOT_W'(1);
    end
  end

  assign last_slot = (slot == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux1_4.sv
// Sequential 1:4 demultiplexer for a 4-channel TDM link. Words are routed
// either by the external select S (direct mode) or by a slot counter that
// is aligned by frame_sync (TDM mode). All outputs are registered.
module tdm_demux1_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic           clk,
  input logic           rst_n,
  tdm_demux1_4_if.slave bus
);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [SLOT_W-1:0] slot;
  logic              last_slot;
  logic              ctr_clear;
  logic              ctr_load;
  logic              ctr_adv;
  logic [NUM_CH-1:0] wr_en;
  logic              fv_nxt;
  logic              fe_nxt;
  logic [WIDTH-1:0]  y_q [NUM_CH];
  logic [NUM_CH-1:0] y_valid_q;
  logic              frame_valid_q;
  logic              frame_err_q;

  tdm_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ctr_clear),
    .load_one  (ctr_load),
    .advance   (ctr_adv),
    .slot      (slot),
    .last_slot (last_slot)
  );

  // Decide which channel the current word lands in and how framing moves on.
  always_comb begin
    state_nxt = state;
    ctr_clear = 1'b0;
    ctr_load  = 1'b0;
    ctr_adv   = 1'b0;
    wr_en     = '0;
    fv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    if (bus.ext_sel) begin
      ctr_clear = 1'b1;
      state_nxt = HUNT;
      if (bus.din_valid) begin
        wr_en = NUM_CH'(1) << bus.S;
      end
    end else if (bus.din_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en     = NUM_CH'(1);
            ctr_load  = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.frame_sync) begin
            wr_en    = NUM_CH'(1);
            ctr_load = 1'b1;
            fe_nxt   = (slot != '0);
          end else begin
            wr_en   = NUM_CH'(1) << slot;
            ctr_adv = 1'b1;
            fv_nxt  = last_slot;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Framing state, channel registers and one-cycle status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      y_valid_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      state         <= state_nxt;
      y_valid_q     <= wr_en;
      frame_valid_q <= fv_nxt;
      frame_err_q   <= fe_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en[i]) begin
          y_q[i] <= bus.din;
        end
      end
    end
  end

  assign bus.Y0          = y_q[0];
  assign bus.Y1          = y_q[1];
  assign bus.Y2          = y_q[2];
  assign bus.Y3          = y_q[3];
  assign bus.y_valid     = y_valid_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// Self-checking bench for tdm_demux1_4. A reference model pushes the
// expected registered outputs for every driven cycle; the observed outputs
// are pushed one clock later and each scenario task compares the two queues.
module tb_tdm_demux1_4;
  import tdm_pkg::*;

  localparam int WIDTH = 1;
  localparam int OBS_W = 4 * WIDTH + NUM_CH + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tdm_demux1_4_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux1_4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [OBS_W-1:0] exp_q [$];
  logic [OBS_W-1:0] obs_q [$];

  logic [WIDTH-1:0] m_y [NUM_CH];
  logic             m_run;
  logic [1:0]       m_slot;

  function automatic logic [OBS_W-1:0] observe();
    return {bus.Y3, bus.Y2, bus.Y1, bus.Y0, bus.y_valid, bus.frame_valid, bus.frame_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_y[i] = '0;
    m_run  = 1'b0;
    m_slot = 2'd0;
  endtask

  task automatic drive(input logic dv, input logic fs, input logic [WIDTH-1:0] d,
                       input logic ext, input logic [1:0] s);
    logic [NUM_CH-1:0] yv;
    logic fv;
    logic fe;
    yv = '0;
    fv = 1'b0;
    fe = 1'b0;
    bus.din_valid  = dv;
    bus.frame_sync = fs;
    bus.din        = d;
    bus.ext_sel    = ext;
    bus.S          = s;
    if (ext) begin
      if (dv) begin
        m_y[s] = d;
        yv[s]  = 1'b1;
      end
      m_run  = 1'b0;
      m_slot = 2'd0;
    end else if (dv) begin
      if (!m_run) begin
        if (fs) begin
          m_y[0] = d;
          yv[0]  = 1'b1;
          m_slot = 2'd1;
          m_run  = 1'b1;
        end
      end else if (fs) begin
        fe     = (m_slot != 2'd0);
        m_y[0] = d;
        yv[0]  = 1'b1;
        m_slot = 2'd1;
      end else begin
        m_y[m_slot] = d;
        yv[m_slot]  = 1'b1;
        fv          = (m_slot == 2'd3);
        m_slot      = m_slot + 2'd1;
      end
    end
    exp_q.push_back({m_y[3], m_y[2], m_y[1], m_y[0], yv, fv, fe});
    @(posedge clk);
    #1;
    obs_q.push_back(observe());
  endtask

  task automatic word(input logic [WIDTH-1:0] d, input logic fs);
    drive(1'b1, fs, d, 1'b0, 2'd0);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    bus.din = '0; bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
    bus.ext_sel = 1'b0; bus.S = 2'd0;
    model_reset();
    #12;
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %b want %b", observe(), {OBS_W{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tdm_frame();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    int fv_seen = 0;
    word(1'b1, 1'b1);
    word(1'b0, 1'b0);
    word(1'b1, 1'b0);
    word(1'b1, 1'b0);
    gap();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o[1]) fv_seen++;
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL tdm_frame beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
    total++;
    if (fv_seen != 1) begin
      bad++;
      $display("[TB] FAIL tdm_frame_valid_count: got %0d want 1", fv_seen);
    end
  endtask

  task automatic test_gaps();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    word(1'b1, 1'b1);
    word(1'b0, 1'b0);
    gap();
    gap();
    word(1'b1, 1'b0);
    word(1'b1, 1'b0);
    gap();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL gaps beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_misalign();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    word(1'b0, 1'b1);
    word(1'b1, 1'b0);
    word(1'b1, 1'b1);
    word(1'b0, 1'b0);
    word(1'b1, 1'b0);
    word(1'b0, 1'b0);
    word(1'b1, 1'b0);
    gap();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL misalign beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_direct();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int s = 0; s < NUM_CH; s++) begin
        drive(1'b1, (s == 1), WIDTH'(s == k), 1'b1, 2'(s));
      end
    end
    word(1'b1, 1'b1);
    word(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
    word(1'b0, 1'b0);
    word(1'b1, 1'b0);
    gap();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL direct beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    word(1'b1, 1'b1);
    word(1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL reset_pre beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_async: got %b want %b", observe(), {OBS_W{1'b0}});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hunt_drop();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    word(1'b1, 1'b0);
    word(1'b1, 1'b0);
    word(1'b1, 1'b0);
    word(1'b1, 1'b1);
    word(1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL hunt_drop beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] e, o;
    int n = 0;
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            WIDTH'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL random beat%0d: got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_tdm_frame();
    test_gaps();
    test_misalign();
    test_direct();
    test_reset_midrun();
    test_hunt_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
